// File: rtl/qn_daq_pkg.sv
// rtl/qn_daq_pkg.sv - shared types and constants for the muon DAQ readout path
package qn_daq_pkg;

  localparam logic [7:0] HEADER_TAG  = 8'hFF;
  localparam int         FIFO_WORD_W = 16;
  localparam int         TUBE_CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SETTLE,
    ST_SNAP,
    ST_HEADER,
    ST_TUBES,
    ST_CLEAR
  } state_t;

  function automatic logic [FIFO_WORD_W-1:0] make_word(input logic [7:0] tag,
                                                       input logic [TUBE_CNT_W-1:0] payload);
    return {tag, payload};
  endfunction

endpackage

// File: rtl/tube_snapshot.sv
// rtl/tube_snapshot.sv - frozen copy of all tube counts with an index read mux
module tube_snapshot
  import qn_daq_pkg::*;
#(
  parameter int NUM_TUBES = 8
) (
  input  logic                              clk,
  input  logic                              clr_n,
  input  logic                              load,
  input  logic [NUM_TUBES*TUBE_CNT_W-1:0]   tube_data,
  input  logic [7:0]                        idx,
  output logic [TUBE_CNT_W-1:0]             cnt
);

  logic [TUBE_CNT_W-1:0] snap [NUM_TUBES];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < NUM_TUBES; i++) snap[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_TUBES; i++) snap[i] <= tube_data[i*TUBE_CNT_W +: TUBE_CNT_W];
    end
  end

  // Out-of-range indices read as zero rather than aliasing another tube.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_TUBES; i++) begin
      if (idx == 8'(i)) cnt = snap[i];
    end
  end

endmodule

// File: rtl/tube_readout.sv
// rtl/tube_readout.sv - drains tube counters into the event FIFO after each gate window
module tube_readout
  import qn_daq_pkg::*;
#(
  parameter int NUM_TUBES  = 8,
  parameter int CLR_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            clr_n,
  input  logic                            gate_enable,
  input  logic [NUM_TUBES*TUBE_CNT_W-1:0] tube_data,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [FIFO_WORD_W-1:0]          fifo_din,
  output logic                            tube_clr,
  output logic                            busy,
  output logic [7:0]                      event_cnt,
  output logic [7:0]                      missed_cnt
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  state_t                state;
  state_t                next_state;
  logic                  gate_q;
  logic                  gate_rise;
  logic                  gate_fall;
  logic [7:0]            idx;
  logic [CLR_W-1:0]      clr_cnt;
  logic [TUBE_CNT_W-1:0] snap_cnt;
  logic                  last_tube;
  logic                  clr_done;

  assign gate_rise = gate_enable & ~gate_q;
  assign gate_fall = ~gate_enable & gate_q;
  assign last_tube = (idx == 8'(NUM_TUBES - 1));
  assign clr_done  = (clr_cnt == CLR_W'(CLR_CYCLES - 1));

  tube_snapshot #(
    .NUM_TUBES (NUM_TUBES)
  ) u_snapshot (
    .clk       (clk),
    .clr_n     (clr_n),
    .load      (state == ST_SNAP),
    .tube_data (tube_data),
    .idx       (idx),
    .cnt       (snap_cnt)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (gate_rise) next_state = ST_ARMED;
      end
      ST_ARMED: begin
        busy = 1'b0;
        if (gate_fall) next_state = ST_SETTLE;
      end
      ST_SETTLE: next_state = ST_SNAP;
      ST_SNAP:   next_state = ST_HEADER;
      ST_HEADER: begin
        fifo_wr_en = ~fifo_full;
        fifo_din   = make_word(HEADER_TAG, event_cnt);
        if (!fifo_full) next_state = ST_TUBES;
      end
      ST_TUBES: begin
        fifo_wr_en = ~fifo_full;
        fifo_din   = make_word(idx, snap_cnt);
        if (!fifo_full && last_tube) next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clr_done) next_state = ST_IDLE;
      end
      default: begin
        busy       = 1'b0;
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      gate_q     <= 1'b0;
      idx        <= '0;
      clr_cnt    <= '0;
      tube_clr   <= 1'b0;
      event_cnt  <= '0;
      missed_cnt <= '0;
    end else begin
      gate_q   <= gate_enable;
      // Registered from next_state so the clear lines up exactly with CLEAR.
      tube_clr <= (next_state == ST_CLEAR);

      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      else                   clr_cnt <= '0;

      if (state == ST_SNAP) begin
        idx <= '0;
      end else if (state == ST_TUBES && !fifo_full) begin
        idx <= last_tube ? 8'd0 : idx + 8'd1;
      end

      if (state == ST_HEADER && !fifo_full) event_cnt <= event_cnt + 8'd1;

      if (gate_rise && busy && missed_cnt != 8'hFF) missed_cnt <= missed_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_tube_readout.sv
// tb/tb_tube_readout.sv - directed bench for tube_readout with NUM_TUBES=4, CLR_CYCLES=2
module tb_tube_readout;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        gate_enable = 1'b0;
  logic        fifo_full = 1'b0;
  logic [31:0] tube_data;
  logic        fifo_wr_en;
  logic [15:0] fifo_din;
  logic        tube_clr;
  logic        busy;
  logic [7:0]  event_cnt;
  logic [7:0]  missed_cnt;

  tube_readout #(
    .NUM_TUBES  (4),
    .CLR_CYCLES (2)
  ) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .gate_enable (gate_enable),
    .tube_data   (tube_data),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_din    (fifo_din),
    .tube_clr    (tube_clr),
    .busy        (busy),
    .event_cnt   (event_cnt),
    .missed_cnt  (missed_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] wq[$];
  int          wc[$];
  int          clr_c[$];
  int          wr_full_viol = 0;

  always @(negedge clk) begin
    if (fifo_wr_en) begin
      wq.push_back(fifo_din);
      wc.push_back(cyc);
    end
    if (tube_clr) clr_c.push_back(cyc);
    if (fifo_wr_en && fifo_full) wr_full_viol++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] cnt_base [4] = '{8'd10, 8'd20, 8'd30, 8'd255};

  task automatic pulse_gate(input int hi);
    @(posedge clk); #1 gate_enable = 1'b1;
    repeat (hi) @(posedge clk);
    #1 gate_enable = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int t = 0;
    while (wq.size() < n && t < 60) begin
      @(negedge clk); #1;
      t++;
    end
    if (wq.size() < n) check("word_timeout", wq.size(), n);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b1 && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
    while (busy !== 1'b0 && t < 120) begin
      @(negedge clk); #1;
      t++;
    end
    if (busy !== 1'b0) check("idle_timeout", busy, 0);
  endtask

  task automatic check_event(input int base, input logic [7:0] hdr, input string tag, input int span);
    logic [15:0] exp;
    check({tag, "_nwords"}, wq.size() - base, 5);
    if (wq.size() - base == 5) begin
      for (int k = 0; k < 5; k++) begin
        exp = (k == 0) ? {8'hFF, hdr} : {8'(k - 1), cnt_base[k - 1]};
        check({tag, "_word"}, wq[base + k], exp);
      end
      check({tag, "_span"}, wc[base + 4] - wc[base], span);
    end
  endtask

  initial begin
    int base;
    int cbase;
    tube_data = {8'd255, 8'd30, 8'd20, 8'd10};
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_din", fifo_din, 0);
    check("rst_tube_clr", tube_clr, 0);
    check("rst_busy", busy, 0);
    check("rst_event_cnt", event_cnt, 0);
    check("rst_missed_cnt", missed_cnt, 0);
    clr_n = 1'b1;

    // Plain event, gate high 5 cycles.
    base  = wq.size();
    cbase = clr_c.size();
    pulse_gate(5);
    wait_idle();
    check_event(base, 8'h00, "ev1", 4);
    check("ev1_clr_len", clr_c.size() - cbase, 2);
    if (clr_c.size() - cbase == 2 && wq.size() - base == 5) begin
      check("ev1_clr_first", clr_c[cbase], wc[base + 4] + 1);
      check("ev1_clr_second", clr_c[cbase + 1], wc[base + 4] + 2);
    end
    check("ev1_event_cnt", event_cnt, 1);

    // Backpressure for 3 cycles while tube 1 is pending.
    base = wq.size();
    pulse_gate(3);
    wait_words(base + 2);
    @(posedge clk); #1 fifo_full = 1'b1;
    repeat (3) @(posedge clk);
    #1 fifo_full = 1'b0;
    wait_idle();
    check_event(base, 8'h01, "ev2", 7);

    // Counters change right after the snapshot.
    base = wq.size();
    pulse_gate(3);
    wait_words(base + 1);
    tube_data = 32'h7777_7777;
    wait_idle();
    check_event(base, 8'h02, "ev3", 4);
    tube_data = {8'd255, 8'd30, 8'd20, 8'd10};

    // Gate re-opens twice while the readout is still running.
    base = wq.size();
    pulse_gate(3);
    wait_words(base + 2);
    @(posedge clk); #1 gate_enable = 1'b1;
    @(posedge clk); #1 gate_enable = 1'b0;
    @(posedge clk); #1 gate_enable = 1'b1;
    @(posedge clk); #1 gate_enable = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    #1;
    check("ev4_missed", missed_cnt, 2);
    check("ev4_no_restart", busy, 0);
    check_event(base, 8'h03, "ev4", 4);

    base = wq.size();
    pulse_gate(2);
    wait_idle();
    check_event(base, 8'h04, "ev5", 4);
    check("ev5_event_cnt", event_cnt, 5);

    // Reset in the middle of TUBES with idx=2.
    base = wq.size();
    pulse_gate(2);
    wait_words(base + 3);
    @(posedge clk); #1 clr_n = 1'b0;
    #1;
    check("abort_wr_en", fifo_wr_en, 0);
    check("abort_tube_clr", tube_clr, 0);
    check("abort_busy", busy, 0);
    check("abort_event_cnt", event_cnt, 0);
    check("abort_missed_cnt", missed_cnt, 0);
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_nwords", wq.size() - base, 3);
    check("abort_idle", busy, 0);

    // 257 back-to-back events: header byte walks 00..FF then wraps to 00.
    for (int k = 0; k <= 256; k++) begin
      base = wq.size();
      pulse_gate(2);
      wait_idle();
      if (k == 0 || k == 256) begin
        check_event(base, 8'(k), "wrap_ev", 4);
      end else if (wq.size() > base) begin
        check("wrap_hdr", wq[base], {8'hFF, 8'(k)});
      end else begin
        check("wrap_hdr_missing", wq.size() - base, 5);
      end
      if (k == 255) check("wrap_event_cnt", event_cnt, 0);
    end
    check("final_event_cnt", event_cnt, 1);
    check("wr_while_full", wr_full_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
